mac_result_drain: RTL and testbench

Consumer end of the mac_array result interface. On `valid_out` it snapshots the full MAC_WIDTH x MAC_WIDTH accumulator bank, then streams it out one row per beat over a valid/ready interface to the writeback/DMA path. It frees the array to accumulate the next tile while the previous tile drains.

---
 rtl/mac_pkg.sv | 9 +
 rtl/mac_result_drain_if.sv | 23 ++
 rtl/mac_requant_lane.sv | 16 +
 rtl/mac_result_drain.sv | 75 +++++++
 tb/tb_mac_result_drain.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, drain FSM states and int8 saturation bounds for the MAC result path
package mac_pkg;
  localparam int DEF_MAC_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int SHIFT_W = 5;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
  typedef enum logic {IDLE, DRAIN} drain_state_e;
endpackage

// File: rtl/mac_result_drain_if.sv
// mac_result_drain_if: snapshot-in / row-stream-out bundle; master is the drain, slave its environment
interface mac_result_drain_if import mac_pkg::*; #(
  parameter int MAC_WIDTH = DEF_MAC_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) ();
  logic acc_valid;
  logic acc_ready;
  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] accumulators;
  logic [SHIFT_W-1:0] shift_amt;
  logic out_valid;
  logic out_ready;
  logic [MAC_WIDTH*ACC_WIDTH-1:0] out_data;
  logic [$clog2(MAC_WIDTH)-1:0] out_row;
  logic out_last;
  modport master (
    input acc_valid, accumulators, shift_amt, out_ready,
    output acc_ready, out_valid, out_data, out_row, out_last
  );
  modport slave (
    output acc_valid, accumulators, shift_amt, out_ready,
    input acc_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/mac_requant_lane.sv
// mac_requant_lane: arithmetic right shift (floor) then saturate to int8, sign-extended to ACC_WIDTH
module mac_requant_lane import mac_pkg::*; #(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [ACC_WIDTH-1:0] q
);
  localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(INT8_MAX);
  localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(INT8_MIN);
  logic signed [ACC_WIDTH-1:0] sh;
  always_comb begin
    sh = $signed(acc) >>> shift;
    q = sh > HI ? HI : sh < LO ? LO : sh;
  end
endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: snapshot the accumulator bank and stream it one row per beat.
// Define MAC_DRAIN_REQUANT_EN to requantize each lane to saturated int8 before output.
module mac_result_drain import mac_pkg::*; #(
  parameter int MAC_WIDTH = DEF_MAC_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  mac_result_drain_if.master   io,
  output logic [CNT_WIDTH-1:0] tiles_done,
  output logic                 busy
);
  localparam int RW = MAC_WIDTH*ACC_WIDTH;
  localparam int ROW_W = $clog2(MAC_WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAC_WIDTH-1);
  drain_state_e state, state_d;
  logic [RW-1:0] buf_q [MAC_WIDTH];
  logic [SHIFT_W-1:0] shift_q, shift_sel;
  logic [RW-1:0] raw_line, next_line;
  logic [ROW_W-1:0] next_row;
  logic capture, beat, last_beat;
  assign io.acc_ready = state == IDLE && !flush;
  assign io.out_valid = state == DRAIN;
  assign io.out_last = io.out_valid && io.out_row == LAST_ROW;
  assign busy = state != IDLE;
  always_comb begin
    capture = io.acc_ready && io.acc_valid;
    beat = io.out_valid && io.out_ready;
    last_beat = beat && io.out_last;
    next_row = io.out_row + 1'b1;
    state_d = flush ? IDLE : capture ? DRAIN : last_beat ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // At capture the buffer is still being written, so row 0 comes straight off the bus
  assign raw_line = capture ? io.accumulators[RW-1:0] : buf_q[next_row];
  assign shift_sel = capture ? io.shift_amt : shift_q;
`ifdef MAC_DRAIN_REQUANT_EN
  for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_lane
    mac_requant_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .acc(raw_line[j*ACC_WIDTH +: ACC_WIDTH]),
      .shift(shift_sel),
      .q(next_line[j*ACC_WIDTH +: ACC_WIDTH])
    );
  end
`else
  logic unused_shift;
  assign unused_shift = ^shift_sel;
  assign next_line = raw_line;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MAC_WIDTH; i++) buf_q[i] <= '0;
      shift_q <= '0;
      io.out_data <= '0;
      io.out_row <= '0;
      tiles_done <= '0;
    end else if (flush) begin
      io.out_row <= '0;
    end else if (capture) begin
      for (int i = 0; i < MAC_WIDTH; i++) buf_q[i] <= io.accumulators[i*RW +: RW];
      shift_q <= io.shift_amt;
      io.out_data <= next_line;
      io.out_row <= '0;
    end else if (last_beat) begin
      io.out_row <= '0;
      tiles_done <= tiles_done + 1'b1;
    end else if (beat) begin
      io.out_data <= next_line;
      io.out_row <= next_row;
    end
endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: randomized drain traffic checked against a beat-queue reference model
module tb_mac_result_drain;
  import mac_pkg::*;
  localparam int MW = 8;
  localparam int AW = 32;
  localparam int RW = MW*AW;
  localparam int BW = MW*RW;
  typedef struct { logic [RW-1:0] d; int r; } beat_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic [15:0] tiles_done;
  logic busy;
  int n_tests = 0;
  int n_fail = 0;
  int tiles_m = 0;
  beat_t q[$];
  always #5 clk = ~clk;
  mac_result_drain_if #(.MAC_WIDTH(MW), .ACC_WIDTH(AW)) io ();
  mac_result_drain #(.MAC_WIDTH(MW), .ACC_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .io(io.master),
    .tiles_done(tiles_done), .busy(busy)
  );
  task automatic check(string tag, logic [RW-1:0] got, logic [RW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [AW-1:0] rq(logic [AW-1:0] v, logic [4:0] s);
    longint x;
    x = longint'($signed(v)) >>> s;
    if (x > 127) x = 127;
    if (x < -128) x = -128;
    return AW'(x);
  endfunction
  function automatic logic [RW-1:0] row_exp(logic [BW-1:0] bus, int r, logic [4:0] s);
    logic [AW-1:0] v;
    for (int j = 0; j < MW; j++) begin
      v = bus[(r*MW+j)*AW +: AW];
`ifdef MAC_DRAIN_REQUANT_EN
      v = rq(v, s);
`endif
      row_exp[j*AW +: AW] = v;
    end
  endfunction
  function automatic logic [BW-1:0] ramp();
    for (int k = 0; k < MW*MW; k++) ramp[k*AW +: AW] = AW'(k);
  endfunction
  function automatic logic [BW-1:0] rand_bus();
    for (int k = 0; k < MW*MW; k++) rand_bus[k*AW +: AW] = $urandom;
  endfunction
  // Check current outputs against the model, advance the model by one edge, then check the counter
  task automatic step();
    #1;
    check("acc_ready", io.acc_ready, q.size() == 0 && !flush);
    check("out_valid", io.out_valid, q.size() != 0);
    check("busy", busy, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", io.out_data, q[0].d);
      check("out_row", io.out_row, q[0].r);
      check("out_last", io.out_last, q[0].r == MW-1);
    end else check("out_last", io.out_last, 0);
    if (flush) q.delete();
    else if (q.size() == 0 && io.acc_valid)
      for (int r = 0; r < MW; r++) q.push_back('{row_exp(io.accumulators, r, io.shift_amt), r});
    else if (q.size() != 0 && io.out_ready) begin
      if (q[0].r == MW-1) tiles_m++;
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    check("tiles_done", tiles_done, 16'(tiles_m));
  endtask
  task automatic load(logic [BW-1:0] b, logic [4:0] s);
    io.accumulators = b;
    io.shift_amt = s;
    io.acc_valid = 1;
    step();
    io.acc_valid = 0;
  endtask
  task automatic run_until_row(int row);
    int n = 0;
    while ((q.size() == 0 || q[0].r != row) && n < 20) begin
      step();
      n++;
    end
    check("row_reached", n < 20, 1);
  endtask
  task automatic drain_all();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_bound", n < 40, 1);
    step();
  endtask
  initial begin
    int n;
    int t0;
    logic [BW-1:0] b;
    logic [31:0] rv [5];
    logic [31:0] re [5];
    rv = '{32'd1000, -32'sd1000, 32'd16129, -32'sd40000, 32'h7FFFFFFF};
    re = '{32'd62, -32'sd63, 32'd127, -32'sd128, 32'd127};
    io.acc_valid = 0;
    io.accumulators = '0;
    io.shift_amt = '0;
    io.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_data", io.out_data, 0);
    check("rst_out_row", io.out_row, 0);
    check("rst_out_last", io.out_last, 0);
    check("rst_tiles", tiles_done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    io.out_ready = 1;
    load(ramp(), 0);
    drain_all();
    check("basic_tiles", tiles_done, 1);
    load(ramp(), 0);
    run_until_row(2);
    io.out_ready = 0;
    repeat (3) step();
    io.out_ready = 1;
    drain_all();
    t0 = tiles_m;
    io.accumulators = rand_bus();
    io.shift_amt = 5'($urandom);
    io.acc_valid = 1;
    step();
    io.accumulators = '1;
    n = 0;
    while (tiles_m < t0 + 1 && n < 20) begin
      step();
      n++;
    end
    check("snap_bound", n < 20, 1);
    step();
    io.acc_valid = 0;
    drain_all();
    check("snap_tiles", tiles_m, t0 + 2);
    load(rand_bus(), 5'($urandom));
    run_until_row(4);
    flush = 1;
    step();
    flush = 0;
    check("flush_idle", busy, 0);
    load(ramp(), 0);
    drain_all();
    flush = 1;
    io.acc_valid = 1;
    step();
    flush = 0;
    io.acc_valid = 0;
    step();
`ifdef MAC_DRAIN_REQUANT_EN
    b = '0;
    for (int k = 0; k < 5; k++) b[k*AW +: AW] = rv[k];
    load(b, 4);
    for (int k = 0; k < 5; k++) check($sformatf("requant_%0d", k), io.out_data[k*AW +: AW], re[k]);
    drain_all();
`else
    b = '0;
    for (int k = 0; k < 5; k++) b[k*AW +: AW] = rv[k];
    load(b, 4);
    for (int k = 0; k < 5; k++) check($sformatf("raw_%0d", k), io.out_data[k*AW +: AW], rv[k]);
    drain_all();
`endif
    for (int c = 0; c < 400; c++) begin
      flush = $urandom_range(0, 19) == 0;
      io.acc_valid = $urandom_range(0, 2) != 0;
      io.out_ready = $urandom_range(0, 3) != 0;
      io.accumulators = rand_bus();
      io.shift_amt = 5'($urandom);
      step();
    end
    flush = 0;
    io.acc_valid = 0;
    io.out_ready = 1;
    drain_all();
    load(rand_bus(), 0);
    run_until_row(5);
    rst_n = 0;
    #1;
    check("arst_out_valid", io.out_valid, 0);
    check("arst_out_row", io.out_row, 0);
    check("arst_tiles", tiles_done, 0);
    check("arst_busy", busy, 0);
    q.delete();
    tiles_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    load(ramp(), 0);
    drain_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
